hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It generates per-stage stall and flush controls for the F/D/E/M/W pipeline registers, including the MEM→WB register, and produces EX-stage forwarding selects. It also sequences two multi-cycle events: the iterative divider in E and data-memory wait states in M. It sits beside the datapath and drives only control signals.

## Interface
- DIV_CYCLES, 32, divider latency in cycles (≥2)
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before error (≥1, ≤255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RsD, RtD  in  5  source registers in D
- RsE, RtE  in  5  source registers in E
- WriteRegM, WriteRegW  in  5  destination registers in M/W
- RegWriteM, RegWriteW  in  1  write enables in M/W
- MemToRegE  in  1  E holds a load
- BranchTakenE  in  1  branch/jump resolved taken in E
- DivStartE  in  1  E holds a divide (level, held while in E)
- MemReqM, MemReadyM  in  1  data-memory request in M / ack
- StallF, StallD, StallE, StallM  out  1  hold the stage register
- FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the stage register
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- DivBusy  out  1  FSM in DIV_WAIT
- DivDone  out  1  one-cycle pulse when the divide completes
- MemErr  out  1  sticky memory-timeout flag

## Operation
- FSM states: RUN, DIV_WAIT, MEM_WAIT. Counter: 8-bit for memory, width $clog2(DIV_CYCLES) for the divider.
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWriteM and WriteRegM≠0 and WriteRegM==RsE.
  - Otherwise 01 if RegWriteW and WriteRegW≠0 and WriteRegW==RsE.
  - Otherwise 00.
  - ForwardBE uses RtE with the same rules. M has priority over W.
- memStall = (state==MEM_WAIT and !MemReadyM) or (state==RUN and MemReqM and !MemReadyM).
  - Effect: StallF/D/E/M=1, FlushW=1. All other flushes are 0.
  - RUN→MEM_WAIT on memStall. The counter loads 1.
  - MEM_WAIT→RUN in the cycle MemReadyM=1. The stall drops in that same cycle.
- MEM_WAIT timeout: the counter increments each cycle. When it equals MEM_TIMEOUT with MemReadyM=0:
  - MemErr is set; it stays set until reset.
  - State returns to RUN.
  - Stall is released in that cycle.
- DIV_WAIT entry: RUN, DivStartE=1, no memStall, and divArmed=1 → DIV_WAIT. The counter loads DIV_CYCLES-1.
  - In DIV_WAIT: StallF/D/E=1, FlushM=1, DivBusy=1. MemReqM is ignored.
  - The counter decrements; at 0, state returns to RUN and DivDone=1.
- divArmed: cleared on DivDone, set when E advances (StallE=0 and DivDone=0). This prevents the same divide from restarting while it is still in E.
- Load-use (RUN only, no mem/div stall): MemToRegE and RtE≠0 and (RtE==RsD or RtE==RtD) → StallF, StallD, FlushE.
- Branch (RUN only, no stall of E): BranchTakenE → FlushD, FlushE. The branch wins over load-use: with both active, StallF/StallD=0 and FlushD/FlushE=1.
- Priority: memStall > DIV_WAIT/div entry > branch > load-use. A lower-priority condition that is suppressed stays pending because its stage is held.

## Timing
- Reset: state=RUN, counters=0, divArmed=1, MemErr=0. All outputs are 0 while rst=0 with idle inputs.
- Stall, flush and forward outputs are combinational from inputs and state; they are valid in the same cycle.
- Divide: stalls are asserted for DIV_CYCLES cycles, starting in the cycle after DivStartE is sampled.
- Memory: a stall lasts N cycles when MemReadyM arrives N cycles after MemReqM. N=0 gives no stall.
- Reset mid-operation aborts DIV_WAIT/MEM_WAIT immediately. No DivDone pulse is produced.

## Structure
- Shared package (core_pkg): state enum {RUN, DIV_WAIT, MEM_WAIT}, forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice (Rs, Rt).
- hazard_ctrl holds the FSM, counters, divArmed, MemErr and the priority logic.

## Test plan
- Forwarding: RsE=5, WriteRegM=5, WriteRegW=5, both RegWrite=1 → ForwardAE=10. With WriteRegM=0 → 01. With RegWriteW=0 as well → 00.
- Load-use: MemToRegE=1, RtE=RsD=8 → StallF=StallD=FlushE=1 for 1 cycle. With RtE=0 → no stall.
- Divide: DivStartE held with DIV_CYCLES=4 → DivBusy for 4 cycles, FlushM=1 during them, DivDone pulse on the 4th, no restart afterwards.
- Memory wait: MemReqM=1 with MemReadyM arriving 3 cycles later → StallM/FlushW=1 for 3 cycles, released in the ack cycle.
- Timeout: MEM_TIMEOUT=4 with no ack → MemErr rises after 4 cycles and stays set until rst=0.
- Collisions:
  - BranchTakenE together with load-use → FlushD/E=1, no stall.
  - DivStartE together with memStall → memory stall serviced first, then DIV_WAIT.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the pipeline control slice: hazard FSM states and
// EX-stage forwarding select encodings.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX-stage source operand; M has priority over W
// and register 0 is never forwarded.
module fwd_unit
  import core_pkg::*;
(
  input  logic [4:0] src,
  input  logic       reg_write_m,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_w,
  input  logic [4:0] write_reg_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src))
      fwd = FWD_M;
    else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src))
      fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, EX forwarding selects,
// and sequencing of the iterative divider and data-memory wait states.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch and load-use hazards handled here
// DIV_WAIT | divider busy in E; F/D/E held, bubble pushed into M
// MEM_WAIT | data memory has not acked; F..M held, bubble into W
module hazard_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemToRegE,
  input  logic       BranchTakenE,
  input  logic       DivStartE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       DivBusy,
  output logic       DivDone,
  output logic       MemErr
);
  import core_pkg::*;

  localparam int DIV_W = $clog2(DIV_CYCLES);

  hz_state_t        state, state_nxt;
  logic [7:0]       mem_cnt, mem_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic             div_armed;
  logic             mem_timeout;
  logic             load_use;
  logic             err_set;

  fwd_unit u_fwd_a (
    .src         (RsE),
    .reg_write_m (RegWriteM),
    .write_reg_m (WriteRegM),
    .reg_write_w (RegWriteW),
    .write_reg_w (WriteRegW),
    .fwd         (ForwardAE)
  );

  fwd_unit u_fwd_b (
    .src         (RtE),
    .reg_write_m (RegWriteM),
    .write_reg_m (WriteRegM),
    .reg_write_w (RegWriteW),
    .write_reg_w (WriteRegW),
    .fwd         (ForwardBE)
  );

  assign mem_timeout = (state == MEM_WAIT) && !MemReadyM
                       && (mem_cnt == 8'(MEM_TIMEOUT));
  assign load_use    = MemToRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

  always_comb begin
    state_nxt   = state;
    mem_cnt_nxt = mem_cnt;
    div_cnt_nxt = div_cnt;
    err_set     = 1'b0;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    DivBusy     = 1'b0;
    DivDone     = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          state_nxt   = MEM_WAIT;
          mem_cnt_nxt = 8'd1;
        end else if (DivStartE && div_armed) begin
          // divider stalls begin next cycle; lower hazards can't coexist with a divide in E
          state_nxt   = DIV_WAIT;
          div_cnt_nxt = DIV_W'(DIV_CYCLES - 1);
        end else if (BranchTakenE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_nxt   = RUN;
          mem_cnt_nxt = 8'd0;
        end else if (mem_timeout) begin
          state_nxt   = RUN;
          mem_cnt_nxt = 8'd0;
          err_set     = 1'b1;
        end else begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          mem_cnt_nxt = mem_cnt + 8'd1;
        end
      end
      DIV_WAIT: begin
        {StallF, StallD, StallE, FlushM} = 4'b1111;
        DivBusy = 1'b1;
        if (div_cnt == '0) begin
          state_nxt = RUN;
          DivDone   = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      mem_cnt   <= 8'd0;
      div_cnt   <= '0;
      div_armed <= 1'b1;
      MemErr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_cnt <= mem_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      if (err_set)
        MemErr <= 1'b1;
      // re-arm only once the divide has actually left E
      if (DivDone)
        div_armed <= 1'b0;
      else if (!StallE)
        div_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DIV_CYCLES=4 and MEM_TIMEOUT=4.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
  logic       RegWriteM, RegWriteW, MemToRegE, BranchTakenE, DivStartE;
  logic       MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       DivBusy, DivDone, MemErr;
  logic [7:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] CTL_NONE = 8'b0000_0000;
  localparam logic [7:0] CTL_LU   = 8'b1100_0100;
  localparam logic [7:0] CTL_BR   = 8'b0000_1100;
  localparam logic [7:0] CTL_DIV  = 8'b1110_0010;
  localparam logic [7:0] CTL_MEM  = 8'b1111_0001;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE), .DivStartE(DivStartE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .DivBusy(DivBusy), .DivDone(DivDone), .MemErr(MemErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance to the next cycle, leaving room to drive inputs before checking
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    {RsD, RtD, RsE, RtE, WriteRegM, WriteRegW} = '0;
    {RegWriteM, RegWriteW, MemToRegE, BranchTakenE, DivStartE, MemReqM, MemReadyM} = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    chk("rst_ctl", ctl, CTL_NONE);
    chk("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
    chk("rst_div", {DivBusy, DivDone}, 2'b00);
    chk("rst_err", MemErr, 1'b0);
    nxt();
    rst = 1'b1;

    // forwarding
    nxt();
    RsE = 5'd5; WriteRegM = 5'd5; WriteRegW = 5'd5; RegWriteM = 1; RegWriteW = 1;
    #1 chk("fwd_m_prio", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    WriteRegM = 5'd0;
    #1 chk("fwd_w", ForwardAE, 2'b01);
    RegWriteW = 0;
    #1 chk("fwd_rf", ForwardAE, 2'b00);
    RsE = 5'd0; RegWriteM = 1;
    #1 chk("fwd_r0", ForwardAE, 2'b00);
    RtE = 5'd7; WriteRegM = 5'd7; RegWriteM = 0; WriteRegW = 5'd7; RegWriteW = 1;
    #1 chk("fwd_b_w", ForwardBE, 2'b01);
    chk("fwd_ctl", ctl, CTL_NONE);

    // load-use
    nxt(); idle();
    MemToRegE = 1; RtE = 5'd8; RsD = 5'd8;
    #1 chk("lu_rs", ctl, CTL_LU);
    nxt(); idle();
    #1 chk("lu_release", ctl, CTL_NONE);
    MemToRegE = 1; RtE = 5'd9; RtD = 5'd9;
    #1 chk("lu_rt", ctl, CTL_LU);
    RtE = 5'd0; RtD = 5'd0; RsD = 5'd0;
    #1 chk("lu_r0", ctl, CTL_NONE);
    RtE = 5'd8; RsD = 5'd8; BranchTakenE = 1;
    #1 chk("br_over_lu", ctl, CTL_BR);

    // divide
    nxt(); idle();
    DivStartE = 1;
    #1 chk("div_entry_ctl", ctl, CTL_NONE);
    chk("div_entry_busy", DivBusy, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      MemReqM = (i == 2);
      #1 chk("div_busy", DivBusy, 1'b1);
      chk("div_ctl", ctl, CTL_DIV);
      chk("div_done", DivDone, (i == 4) ? 1'b1 : 1'b0);
    end
    nxt(); MemReqM = 0;
    #1 chk("div_norestart", {DivBusy, DivDone}, 2'b00);
    chk("div_after_ctl", ctl, CTL_NONE);
    nxt(); DivStartE = 0;
    #1 chk("div_idle", DivBusy, 1'b0);

    // memory wait, ack three cycles after request
    nxt(); idle();
    MemReqM = 1;
    #1 chk("mem_c0", ctl, CTL_MEM);
    nxt(); #1 chk("mem_c1", ctl, CTL_MEM);
    nxt(); #1 chk("mem_c2", ctl, CTL_MEM);
    nxt(); MemReadyM = 1;
    #1 chk("mem_ack", ctl, CTL_NONE);
    nxt(); MemReqM = 0; MemReadyM = 0;
    #1 chk("mem_after", ctl, CTL_NONE);
    MemReqM = 1; MemReadyM = 1;
    #1 chk("mem_n0", ctl, CTL_NONE);
    nxt(); MemReqM = 0; MemReadyM = 0;
    #1 chk("mem_n0_after", ctl, CTL_NONE);

    // timeout
    nxt(); MemReqM = 1;
    #1 chk("to_c0", ctl, CTL_MEM);
    for (int i = 1; i <= 3; i++) begin
      nxt(); #1 chk("to_wait", ctl, CTL_MEM);
      chk("to_err_low", MemErr, 1'b0);
    end
    nxt(); MemReqM = 0;
    #1 chk("to_release", ctl, CTL_NONE);
    chk("to_err_not_yet", MemErr, 1'b0);
    nxt(); #1 chk("to_err_set", MemErr, 1'b1);
    nxt(); #1 chk("to_err_sticky", MemErr, 1'b1);
    chk("to_run", ctl, CTL_NONE);
    rst = 1'b0;
    #1 chk("to_err_rst", MemErr, 1'b0);
    nxt(); rst = 1'b1;

    // divide colliding with memory stall
    nxt(); DivStartE = 1; MemReqM = 1;
    #1 chk("col_c0", ctl, CTL_MEM);
    chk("col_c0_busy", DivBusy, 1'b0);
    nxt(); #1 chk("col_c1", ctl, CTL_MEM);
    nxt(); MemReadyM = 1;
    #1 chk("col_ack", ctl, CTL_NONE);
    nxt(); MemReqM = 0; MemReadyM = 0;
    #1 chk("col_div_entry", {DivBusy, ctl}, {1'b0, CTL_NONE});
    nxt(); #1 chk("col_div_busy", {DivBusy, ctl}, {1'b1, CTL_DIV});

    // reset mid-divide aborts without DivDone
    nxt(); DivStartE = 0; rst = 1'b0;
    #1 chk("rst_abort", {DivBusy, DivDone, ctl}, {2'b00, CTL_NONE});
    nxt(); rst = 1'b1;
    #1 chk("rst_abort_run", {DivBusy, DivDone}, 2'b00);
    nxt(); #1 chk("rst_abort_idle", ctl, CTL_NONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
